// File: rtl/branch_predict_ctrl.sv
// Branch predictor (2-bit counters indexed by PC) and EX-stage redirect/flush.
// Ports: ID predict in/out, EX resolve in, redirect/flush out, stats counters.
module branch_predict_ctrl #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 4,
  parameter int CNT_W    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            id_valid,
  input  logic            id_is_branch,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  output logic            id_pred_taken,
  output logic [XLEN-1:0] id_pred_target,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int N = 1 << IDX_BITS;
  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]          r_tbl [N];
  logic [CNT_W-1:0]    r_branch_cnt;
  logic [CNT_W-1:0]    r_mispred_cnt;

  logic [IDX_BITS-1:0] w_id_idx;
  logic [IDX_BITS-1:0] w_ex_idx;
  logic                w_fire;
  logic                w_mispred;
  logic [1:0]          w_cur;
  logic [1:0]          w_next;
  logic [XLEN-1:0]     w_seq_pc;

  assign w_id_idx = id_pc[IDX_BITS+1:2];
  assign w_ex_idx = ex_pc[IDX_BITS+1:2];

  assign w_fire    = ex_valid & ex_is_branch & ~stall;
  assign w_mispred = w_fire & (ex_pred_taken != ex_taken);

  // ID sees the pre-update entry; no bypass from the EX write
  assign id_pred_taken  = id_valid & id_is_branch & r_tbl[w_id_idx][1];
  assign id_pred_target = id_pc + id_imm;

  assign w_seq_pc       = ex_pc + PC_STEP;
  assign redirect_valid = w_mispred;
  assign flush_if_id    = w_mispred;
  assign flush_id_ex    = w_mispred;
  assign redirect_pc    = (w_mispred & ex_taken) ? ex_target : w_seq_pc;

  assign w_cur = r_tbl[w_ex_idx];

  // saturating 2-bit counter step
  always_comb begin
    w_next = w_cur;
    unique case (1'b1)
      ex_taken  && (w_cur != 2'b11): w_next = w_cur + 2'd1;
      !ex_taken && (w_cur != 2'b00): w_next = w_cur - 2'd1;
      default:                       w_next = w_cur;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_tbl[i] <= 2'b01;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (w_fire) begin
      r_tbl[w_ex_idx] <= w_next;
      r_branch_cnt    <= r_branch_cnt + CNT_ONE;
      if (w_mispred) r_mispred_cnt <= r_mispred_cnt + CNT_ONE;
    end
  end

  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: random + directed stimulus,
// a counter-table reference model, and a per-cycle output monitor.
module tb_branch_predict_ctrl;

  localparam int CW = 8;
  localparam int CMASK = (1 << CW) - 1;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        stall = 0;
  logic        id_valid = 0, id_is_branch = 0;
  logic [31:0] id_pc = 0, id_imm = 0;
  logic        id_pred_taken;
  logic [31:0] id_pred_target;
  logic        ex_valid = 0, ex_is_branch = 0;
  logic [31:0] ex_pc = 0;
  logic        ex_pred_taken = 0, ex_taken = 0;
  logic [31:0] ex_target = 0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if_id, flush_id_ex;
  logic [CW-1:0] branch_cnt, mispred_cnt;

  branch_predict_ctrl #(.XLEN(32), .IDX_BITS(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .id_valid(id_valid), .id_is_branch(id_is_branch),
    .id_pc(id_pc), .id_imm(id_imm),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          pred;
    logic [31:0] tgt;
    bit          rv;
    logic [31:0] rpc;
    int          bc;
    int          mc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  bit started = 0;

  // reference model: counter value 0..3 per index, taken-prediction when >= 2
  int tbl[16];
  int m_bc, m_mc;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) tbl[i] = 1;
    m_bc = 0;
    m_mc = 0;
  endtask

  function automatic int idx(logic [31:0] pc);
    return (pc / 4) % 16;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(bit s, bit iv, bit ib, logic [31:0] ipc,
                       logic [31:0] iimm, bit ev, bit eb,
                       logic [31:0] epc, bit ept, bit et,
                       logic [31:0] etgt);
    exp_t e;
    bit fire, mis;
    stall = s; id_valid = iv; id_is_branch = ib;
    id_pc = ipc; id_imm = iimm;
    ex_valid = ev; ex_is_branch = eb; ex_pc = epc;
    ex_pred_taken = ept; ex_taken = et; ex_target = etgt;
    fire = ev && eb && !s;
    mis = fire && (ept != et);
    e.pred = iv && ib && (tbl[idx(ipc)] >= 2);
    e.tgt = ipc + iimm;
    e.rv = mis;
    if (mis && et) e.rpc = etgt;
    else e.rpc = epc + 32'd4;
    e.bc = m_bc;
    e.mc = m_mc;
    q.push_back(e);
    started = 1;
    @(posedge clk);
    if (fire) begin
      if (et) tbl[idx(epc)] = (tbl[idx(epc)] == 3) ? 3 : tbl[idx(epc)] + 1;
      else    tbl[idx(epc)] = (tbl[idx(epc)] == 0) ? 0 : tbl[idx(epc)] - 1;
      m_bc = (m_bc + 1) & CMASK;
      if (mis) m_mc = (m_mc + 1) & CMASK;
    end
    #1;
  endtask

  // monitor: one expected record per cycle, checked on the falling edge
  always @(negedge clk) begin
    if (started) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pred_taken", 64'(id_pred_taken), 64'(e.pred));
        chk("pred_target", 64'(id_pred_target), 64'(e.tgt));
        chk("redirect_valid", 64'(redirect_valid), 64'(e.rv));
        chk("flush_if_id", 64'(flush_if_id), 64'(e.rv));
        chk("flush_id_ex", 64'(flush_id_ex), 64'(e.rv));
        chk("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
        chk("branch_cnt", 64'(branch_cnt), 64'(e.bc));
        chk("mispred_cnt", 64'(mispred_cnt), 64'(e.mc));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pc, tgt;
    bit ept, et;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // reset state and first prediction
    drive(0, 1, 1, 32'h100, 32'h20, 0, 0, 0, 0, 0, 0);
    // mispredict taken: redirect to target, entry 01 -> 10
    drive(0, 1, 1, 32'h100, 32'h20, 1, 1, 32'h100, 0, 1, 32'h120);
    drive(0, 1, 1, 32'h100, 32'h20, 0, 0, 0, 0, 0, 0);
    // saturate at 11, correctly predicted
    repeat (3) drive(0, 1, 1, 32'h100, 32'h20, 1, 1, 32'h100, 1, 1, 32'h120);
    // two not-taken mispredicts: 11 -> 10 -> 01, redirect to 0x104
    repeat (2) drive(0, 1, 1, 32'h100, 32'h20, 1, 1, 32'h100, 1, 0, 32'h120);
    drive(0, 1, 1, 32'h100, 32'h20, 0, 0, 0, 0, 0, 0);
    // aliasing: training 0x140 moves the 0x100 prediction
    repeat (2) drive(0, 1, 1, 32'h100, 32'h8, 1, 1, 32'h140, 0, 1, 32'h180);
    drive(0, 1, 1, 32'h103, 32'h8, 0, 0, 0, 0, 0, 0);
    // stalled mispredict: nothing for 3 cycles, one event on release
    repeat (3) drive(1, 0, 0, 0, 0, 1, 1, 32'h200, 0, 1, 32'h300);
    drive(0, 0, 0, 0, 0, 1, 1, 32'h200, 0, 1, 32'h300);
    // non-branch and invalid EX are inert
    drive(0, 1, 0, 32'h100, 32'h4, 1, 0, 32'h100, 0, 1, 32'h500);
    drive(0, 0, 1, 32'h100, 32'h4, 0, 1, 32'h100, 0, 1, 32'h500);
    // PC increment wraps
    drive(0, 1, 1, 32'hFFFF_FFFC, 32'h8, 1, 1, 32'hFFFF_FFFC, 1, 0, 0);
    // counters wrap modulo 2^CNT_W
    for (int i = 0; i < 260; i++)
      drive(0, 0, 0, 0, 0, 1, 1, 32'(i * 4), 1, 0, 32'h40);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      pc = {$urandom_range(0, 63), 2'b00} | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) pc = $urandom;
      tgt = $urandom;
      et = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) ept = (tbl[idx(pc)] >= 2);
      else ept = 1'($urandom_range(0, 1));
      drive(($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            {$urandom_range(0, 63), 2'($urandom_range(0, 3))},
            $urandom,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            pc, ept, et, tgt);
    end

    // async reset mid-cycle after training 0x100 toward taken
    repeat (3) drive(0, 0, 0, 0, 0, 1, 1, 32'h100, 1, 1, 32'h120);
    id_valid = 1; id_is_branch = 1; id_pc = 32'h100; id_imm = 32'h10;
    ex_valid = 0; ex_is_branch = 0; stall = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("async_rst_branch_cnt", 64'(branch_cnt), 64'(0));
    chk("async_rst_mispred_cnt", 64'(mispred_cnt), 64'(0));
    chk("async_rst_pred", 64'(id_pred_taken), 64'(0));
    begin
      exp_t e;
      e.pred = 0; e.tgt = 32'h110; e.rv = 0; e.rpc = ex_pc + 32'd4;
      e.bc = 0; e.mc = 0;
      q.push_back(e);
    end
    @(posedge clk);
    #1 rst_n = 1;
    drive(0, 1, 1, 32'h100, 32'h10, 1, 1, 32'h100, 0, 1, 32'h110);
    drive(0, 1, 1, 32'h100, 32'h10, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    started = 0;
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover act=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
